float_conv_arbiter: RTL
=======================

# float_conv_arbiter

Shares one float-to-signed-16 conversion datapath between `NUM_REQ` requesters, such as voice channels or control-rate modulators. Each converts an IEEE-754 single into a saturated `int16` sample for the DAC path. The block arbitrates round-robin, sequences the registered conversion core, and returns each result tagged with the requester index through a valid/ready response port with backpressure. It sits between the float DSP stages and the fixed-point mixer/output stage.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default 2: width of the requester index; must equal `$clog2(NUM_REQ)`.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester request pending.
- `req_float`  in  NUM_REQ*32: packed float operands; requester i occupies bits [32i+31:32i].
- `req_ready`  out  NUM_REQ: one-hot grant pulse; operand i is consumed in this cycle.
- `resp_valid`  out  1: result available.
- `resp_ready`  in  1: consumer accepts the result.
- `resp_id`  out  ID_W: index of the requester that owns the result.
- `resp_data`  out  16 (signed): converted value.
- `resp_sat`  out  1: result was clamped.
- `busy`  out  1: state is not IDLE.

## Operation
- Conversion fields: sign s=f[31], exponent e=f[30:23], mantissa m={1,f[22:0]}.
- e<127: magnitude 0. This covers denormals and ±0.
- 127≤e≤141: magnitude = (m >> (150−e))[14:0], truncating toward zero.
- e≥142: magnitude 32767 and sat=1. This covers Inf and NaN.
- resp_data = s ? −magnitude : magnitude. A negative zero returns 0. The range is symmetric ±32767; −32768 is never produced.
- State machine, encoding IDLE/CALC/RESP:
  - IDLE: if any req_valid is high, grant the first set bit searching upward from `rr_ptr`, wrapping. Pulse req_ready for the grantee only, latch its operand and index, and go to CALC.
  - CALC: the core registers its result. Go to RESP.
  - RESP: resp_valid=1, with resp_data, resp_id and resp_sat held stable. When resp_ready=1, set rr_ptr=(grantee+1) mod NUM_REQ and go to IDLE.
- Only one conversion is ever in flight.
- req_ready never asserts outside IDLE.
- A requester that drops req_valid before being granted is simply skipped.
- Operands are sampled only in the grant cycle. Later changes on req_float have no effect.

## Timing
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_sat=0, busy=0.
- Latency:
  - Grant in cycle T.
  - resp_valid=1 in cycle T+2.
  - With resp_ready tied high, the next grant occurs at T+3.
- Throughput: one conversion per 3 cycles under continuous ready.
- Backpressure: while resp_ready=0, the block stays in RESP indefinitely and outputs do not change.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ−1,0. No requester waits more than NUM_REQ conversions.
- The pointer advances only on response acceptance, not on grant.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - An in-flight result is discarded and never presented.
  - No req_ready pulse occurs in the reset cycle.
- resp_ready while resp_valid=0 is ignored.

## Structure
- Shared package `synth_dsp_pkg`:
  - field-position constants `FLT_SIGN`, `FLT_EXP_HI/LO`, `FLT_MAN_W`.
  - `EXP_ONE=127` and `EXP_SAT=142`.
  - `S16_MAX=32767`.
  - state enum `fca_state_t`.
- Sub-module `float_to_s16_core`:
  - ports: `clk`, `reset`, `load`, 32-bit `din`, registered 16-bit `dout`, `sat`.
  - one-cycle registered barrel-shift conversion, reusable elsewhere in the DSP path.
- The arbiter holds the FSM, the round-robin pointer, and the operand/index capture registers.

## Test plan
- Single request on req 2 with 0x3F800000 (1.0) → req_ready=4'b0100 at T, resp_valid at T+2, resp_data=1, resp_id=2, resp_sat=0.
- Value sweep on req 0:
  - 0x3F000000 (0.5) → 0.
  - 0xC0700000 (−3.75) → −3.
  - 0x46FFFE00 (32767.0) → 32767, sat=0.
  - 0x47000000 (32768.0) → 32767, sat=1.
  - 0xC7000000 → −32767, sat=1.
  - 0x80000000 → 0.
- All four requesters held valid, resp_ready=1 → grant order 0,1,2,3,0,1, with a grant every 3 cycles and resp_id matching.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP → outputs stable, no req_ready pulses, busy=1. Raising resp_ready for one cycle → next grant goes to the following index.
- Operand change: alter req_float[0] in the cycle after the grant → result still reflects the operand captured at grant.
- Reset asserted in CALC and, in a separate run, in RESP → next cycle all outputs at reset values, discarded result never appears, and the next grant goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/synth_dsp_pkg.sv
// Shared constants and types for the float-to-int16 conversion path.
package synth_dsp_pkg;

    // IEEE-754 single-precision field positions
    localparam int FLT_SIGN   = 31;
    localparam int FLT_EXP_HI = 30;
    localparam int FLT_EXP_LO = 23;
    localparam int FLT_MAN_W  = 23;

    // Biased exponent of 1.0, and the first exponent whose magnitude needs 16+ bits
    localparam logic [7:0] EXP_ONE = 8'd127;
    localparam logic [7:0] EXP_SAT = 8'd142;

    // Symmetric saturation limit; -32768 is never produced
    localparam logic [15:0] S16_MAX = 16'd32767;

    typedef enum logic [1:0] {
        FCA_IDLE = 2'd0,
        FCA_CALC = 2'd1,
        FCA_RESP = 2'd2
    } fca_state_t;

endpackage

// File: rtl/float_to_s16_core.sv
// Registered float32 -> saturated signed 16-bit conversion.
// The result updates one cycle after load and holds until the next load.
module float_to_s16_core
    import synth_dsp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [31:0]        din,
    output logic signed [15:0] dout,
    output logic               sat
);

    logic        sign;
    logic [7:0]  expo;
    logic [23:0] man;
    logic [4:0]  shamt;
    logic [15:0] mag;
    logic        sat_conv;

    logic [15:0] dout_d, dout_q;
    logic        sat_d, sat_q;

    // Field extraction, truncating barrel shift and clamp; capture only on load
    always_comb begin
        sign     = din[FLT_SIGN];
        expo     = din[FLT_EXP_HI:FLT_EXP_LO];
        man      = {1'b1, din[FLT_MAN_W-1:0]};
        shamt    = '0;
        mag      = '0;
        sat_conv = 1'b0;
        if (expo >= EXP_SAT) begin
            mag      = S16_MAX;
            sat_conv = 1'b1;
        end else if (expo >= EXP_ONE) begin
            // exponent 127..141 maps to a right shift of 23..9
            shamt = 5'(8'd150 - expo);
            mag   = {1'b0, 15'(man >> shamt)};
        end

        dout_d = dout_q;
        sat_d  = sat_q;
        if (load) begin
            dout_d = sign ? (16'd0 - mag) : mag;
            sat_d  = sat_conv;
        end
    end

    // Result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            sat_q  <= sat_d;
        end
    end

    assign dout = dout_q;
    assign sat  = sat_q;

endmodule

// File: rtl/float_conv_arbiter.sv
// Round-robin sharing of one float->int16 conversion core between NUM_REQ
// requesters, with a valid/ready response port carrying the requester index.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for any req_valid; grant, capture operand and index
//   CALC     | core registers the conversion of the captured operand
//   RESP     | result presented on resp_*; leave when resp_ready is high
module float_conv_arbiter
    import synth_dsp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_float,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic signed [15:0]    resp_data,
    output logic                  resp_sat,
    output logic                  busy
);

    fca_state_t      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     op_q, op_d;

    logic            any_valid;
    logic            upper_found;
    logic [ID_W-1:0] low_id;
    logic [ID_W-1:0] upper_id;
    logic [ID_W-1:0] pick_id;
    logic [31:0]     pick_float;
    logic            grant;
    logic            core_load;

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall
    always_comb begin
        any_valid   = 1'b0;
        upper_found = 1'b0;
        low_id      = '0;
        upper_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                low_id    = ID_W'(i);
                if (ID_W'(i) >= rr_ptr_q) begin
                    upper_found = 1'b1;
                    upper_id    = ID_W'(i);
                end
            end
        end
        pick_id = upper_found ? upper_id : low_id;
    end

    // Operand select for the picked requester
    always_comb begin
        pick_float = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == pick_id) begin
                pick_float = req_float[i*32 +: 32];
            end
        end
    end

    // Next-state, capture and pointer update
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        grant     = 1'b0;
        core_load = 1'b0;
        case (state_q)
            FCA_IDLE: begin
                if (any_valid) begin
                    grant   = 1'b1;
                    id_d    = pick_id;
                    op_d    = pick_float;
                    state_d = FCA_CALC;
                end
            end
            FCA_CALC: begin
                core_load = 1'b1;
                state_d   = FCA_RESP;
            end
            FCA_RESP: begin
                if (resp_ready) begin
                    // pointer moves only on acceptance, so a stalled response holds priority
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d  = FCA_IDLE;
                end
            end
            default: begin
                state_d = FCA_IDLE;
            end
        endcase
    end

    // State, pointer and capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FCA_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
        end
    end

    float_to_s16_core u_core (
        .clk   (clk),
        .reset (reset),
        .load  (core_load),
        .din   (op_q),
        .dout  (resp_data),
        .sat   (resp_sat)
    );

    // The grant pulse is suppressed in a reset cycle since the capture is discarded
    assign req_ready  = (grant && !reset) ? (NUM_REQ'(1) << pick_id) : '0;
    assign resp_valid = (state_q == FCA_RESP);
    assign resp_id    = id_q;
    assign busy       = (state_q != FCA_IDLE);

endmodule
